button_pulse_gen: RTL and testbench

BUTTON_PULSE_GEN -- requirements
Module: button_pulse_gen

---
 rtl/btn_if.sv | 10 +
 rtl/button_pulse_gen.sv | 127 ++++++++++++
 tb/tb_button_pulse_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/btn_if.sv
// Button bundle between the raw push-button pads and the pulse generator.
// master drives the raw levels; slave (the generator) returns pulses and debounced levels.
interface btn_if;
    logic [4:0] btn_raw;
    logic [4:0] btn_pulse;
    logic [4:0] btn_level;

    modport master (output btn_raw, input btn_pulse, input btn_level);
    modport slave  (input btn_raw, output btn_pulse, output btn_level);
endinterface

// File: rtl/button_pulse_gen.sv
// Per-button sync + debounce + one-cycle press pulse with optional auto-repeat, bits {C,L,R,U,D}.
// Latency: press pulse DEBOUNCE_CYCLES+2 edges after raw rises; no backpressure, pulses are fire-and-forget.
module button_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter int unsigned HOLD_DELAY      = 500,
    parameter int unsigned REPEAT_PERIOD   = 100,
    parameter logic [4:0]  REPEAT_MASK     = 5'b01111
) (
    input  logic clk,
    input  logic rst_n,
    btn_if.slave bus
);

    localparam int unsigned NBTN = 5;
    localparam logic [15:0] DB_LAST     = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST   = 16'(HOLD_DELAY);
    localparam logic [15:0] REPEAT_LAST = 16'(REPEAT_PERIOD);

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        REPEATING  = 1'b1
    } rpt_state_e;

    logic [4:0]  sync1_q, sync1_d;
    logic [4:0]  sync2_q, sync2_d;
    logic [4:0]  level_q, level_d;
    logic [4:0]  pulse_q, pulse_d;
    logic [15:0] db_cnt_q [NBTN];
    logic [15:0] db_cnt_d [NBTN];
    logic [15:0] hold_q   [NBTN];
    logic [15:0] hold_d   [NBTN];
    rpt_state_e  state_q  [NBTN];
    rpt_state_e  state_d  [NBTN];
    logic [4:0]  rise_w;
    logic [4:0]  fall_w;

    // Synchronizer and debounce: a level change is accepted only after
    // DEBOUNCE_CYCLES consecutive differing synchronized samples.
    always_comb begin
        sync1_d = bus.btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        for (int i = 0; i < NBTN; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                level_d[i]  = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 16'd1;
            end
        end
    end

    assign rise_w = level_d & ~level_q;
    assign fall_w = level_q & ~level_d;

    // Auto-repeat: the press edge restarts the hold count; the release edge
    // wins over a repeat pulse that would otherwise land on the same cycle.
    always_comb begin
        pulse_d = rise_w;
        for (int i = 0; i < NBTN; i++) begin
            state_d[i] = state_q[i];
            hold_d[i]  = hold_q[i];
            if (rise_w[i]) begin
                state_d[i] = WAIT_FIRST;
                hold_d[i]  = 16'd1;
            end else if (fall_w[i] || !level_q[i]) begin
                state_d[i] = WAIT_FIRST;
                hold_d[i]  = '0;
            end else if (REPEAT_MASK[i]) begin
                case (state_q[i])
                    WAIT_FIRST: begin
                        if (hold_q[i] == HOLD_LAST) begin
                            pulse_d[i] = 1'b1;
                            state_d[i] = REPEATING;
                            hold_d[i]  = 16'd1;
                        end else begin
                            hold_d[i]  = hold_q[i] + 16'd1;
                        end
                    end
                    REPEATING: begin
                        if (hold_q[i] == REPEAT_LAST) begin
                            pulse_d[i] = 1'b1;
                            hold_d[i]  = 16'd1;
                        end else begin
                            hold_d[i]  = hold_q[i] + 16'd1;
                        end
                    end
                    default: begin
                        state_d[i] = WAIT_FIRST;
                        hold_d[i]  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            for (int i = 0; i < NBTN; i++) begin
                db_cnt_q[i] <= '0;
                hold_q[i]   <= '0;
                state_q[i]  <= WAIT_FIRST;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < NBTN; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
                hold_q[i]   <= hold_d[i];
                state_q[i]  <= state_d[i];
            end
        end
    end

    assign bus.btn_pulse = pulse_q;
    assign bus.btn_level = level_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Scoreboarded bench for button_pulse_gen with DEBOUNCE_CYCLES=4, HOLD_DELAY=6, REPEAT_PERIOD=3.
// Edge n is the n-th rising clk after reset release; raw for edge n is applied before it.
module tb_button_pulse_gen;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    btn_if bus ();

    button_pulse_gen #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_DELAY      (6),
        .REPEAT_PERIOD   (3),
        .REPEAT_MASK     (5'b01111)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         edge_n;
        logic [4:0] pulse;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   ecount  = -1;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, ecount);
    endtask

    task automatic expect_pulse(input int edge_n, input logic [4:0] pulse);
        exp_t e;
        e.edge_n = edge_n;
        e.pulse  = pulse;
        sb.push_back(e);
    endtask

    task automatic step(input logic [4:0] raw);
        bus.btn_raw = raw;
        @(posedge clk);
        ecount++;
        #1;
    endtask

    task automatic reset_dut(input string name);
        bus.btn_raw = 5'b0;
        rst_n = 1'b0;
        #1;
        check({name, "_rst_level"}, bus.btn_level, 5'b0);
        check({name, "_rst_pulse"}, bus.btn_pulse, 5'b0);
        repeat (2) @(posedge clk);
        #1;
        ecount = -1;
        rst_n  = 1'b1;
    endtask

    task automatic end_test(input string name);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL %s_missing_pulses: got %0d still pending expected 0", name, sb.size());
        sb.delete();
    endtask

    // Monitor: every nonzero pulse vector must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.btn_pulse !== 5'b0) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_pulse: got %b at edge %0d expected none", bus.btn_pulse, ecount);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.edge_n == ecount && mon_e.pulse === bus.btn_pulse) n_pass++;
                else $display("FAIL pulse: got %b at edge %0d expected %b at edge %0d",
                              bus.btn_pulse, ecount, mon_e.pulse, mon_e.edge_n);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        bus.btn_raw = 5'b0;
        #1;

        // C held 30 cycles: one pulse at edge 5, C never repeats.
        reset_dut("c_hold");
        expect_pulse(5, 5'b10000);
        for (int n = 0; n < 40; n++) begin
            step(n < 30 ? 5'b10000 : 5'b00000);
            if (n == 4)  check("c_level_before", bus.btn_level, 5'b00000);
            if (n == 5)  check("c_level_rise",   bus.btn_level, 5'b10000);
            if (n == 34) check("c_level_held",   bus.btn_level, 5'b10000);
            if (n == 35) check("c_level_fall",   bus.btn_level, 5'b00000);
        end
        end_test("c_hold");

        // 3-cycle glitch on L: nothing happens.
        reset_dut("l_glitch");
        for (int n = 0; n < 20; n++) begin
            step(n < 3 ? 5'b01000 : 5'b00000);
            if (n == 4 || n == 5 || n == 19) check("l_glitch_level", bus.btn_level, 5'b00000);
        end
        end_test("l_glitch");

        // R held: press 5, repeats 11,14,17,20,23; fall at 26 swallows the repeat due there.
        reset_dut("r_repeat");
        expect_pulse(5,  5'b00100);
        expect_pulse(11, 5'b00100);
        expect_pulse(14, 5'b00100);
        expect_pulse(17, 5'b00100);
        expect_pulse(20, 5'b00100);
        expect_pulse(23, 5'b00100);
        for (int n = 0; n < 36; n++) begin
            step(n < 21 ? 5'b00100 : 5'b00000);
            if (n == 25) check("r_level_held", bus.btn_level, 5'b00100);
            if (n == 26) check("r_level_fall", bus.btn_level, 5'b00000);
        end
        end_test("r_repeat");

        // U and D together: one shared pulse cycle, released before the first repeat.
        reset_dut("ud_same");
        expect_pulse(5, 5'b00011);
        for (int n = 0; n < 15; n++) begin
            step(n < 5 ? 5'b00011 : 5'b00000);
            if (n == 4)  check("ud_level_before", bus.btn_level, 5'b00000);
            if (n == 5)  check("ud_level_rise",   bus.btn_level, 5'b00011);
            if (n == 9)  check("ud_level_held",   bus.btn_level, 5'b00011);
            if (n == 10) check("ud_level_fall",   bus.btn_level, 5'b00000);
        end
        end_test("ud_same");

        // C pressed, reset mid-hold, still held through release: fresh press.
        reset_dut("c_reset");
        expect_pulse(5, 5'b10000);
        for (int n = 0; n < 8; n++) step(5'b10000);
        check("c_reset_pre_level", bus.btn_level, 5'b10000);
        rst_n = 1'b0;
        #1;
        check("c_reset_async_level", bus.btn_level, 5'b00000);
        check("c_reset_async_pulse", bus.btn_pulse, 5'b00000);
        repeat (2) @(posedge clk);
        #1;
        ecount = -1;
        rst_n  = 1'b1;
        expect_pulse(5, 5'b10000);
        for (int n = 0; n < 20; n++) begin
            step(n < 15 ? 5'b10000 : 5'b00000);
            if (n == 4) check("c_reset_level_before", bus.btn_level, 5'b00000);
            if (n == 5) check("c_reset_level_rise",   bus.btn_level, 5'b10000);
        end
        end_test("c_reset");

        // D press, 2-cycle gap, re-press: level never drops during the gap.
        reset_dut("d_gap");
        expect_pulse(5,  5'b00001);
        expect_pulse(11, 5'b00001);
        expect_pulse(14, 5'b00001);
        for (int n = 0; n < 25; n++) begin
            step((n < 8 || (n >= 10 && n < 12)) ? 5'b00001 : 5'b00000);
            if (n == 9 || n == 12 || n == 16) check("d_gap_level_held", bus.btn_level, 5'b00001);
            if (n == 17) check("d_gap_level_fall", bus.btn_level, 5'b00000);
        end
        end_test("d_gap");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
